// File: rtl/gpu_dmem_arbiter_pkg.sv
// Shared GPU DMEM width defines and the arbiter package (access-kind enum and its decode).
// Build option: GPU_DMEM_ARB_HOSTPRIO_EN gives requester NREQ-1 absolute priority.
`ifndef GPU_DMEM_ADDR_WIDTH
`define GPU_DMEM_ADDR_WIDTH 10
`endif
`ifndef GPU_DMEM_DATA_WIDTH
`define GPU_DMEM_DATA_WIDTH 32
`endif
`ifndef GPU_DMEM_ARB_NREQ
`define GPU_DMEM_ARB_NREQ 4
`endif

package gpu_dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ACC_IDLE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2
    } acc_kind_e;

    function automatic acc_kind_e acc_kind(input logic any, input logic we);
        if (!any) begin
            return ACC_IDLE;
        end
        return we ? ACC_WRITE : ACC_READ;
    endfunction

endpackage

// File: rtl/gpu_dmem_arbiter_rr_pick.sv
// Rotate-priority encoder: first asserted request at or above i_ptr, searching upward modulo N.
module gpu_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    int w_best_dist;
    int w_dist;

    // Winner is the asserted request with the smallest upward distance from the pointer.
    always_comb begin
        w_best_dist = N;
        w_dist      = 0;
        o_idx       = '0;
        for (int j = 0; j < N; j++) begin
            w_dist = (j + N - int'(i_ptr)) % N;
            if (i_req[j] && (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                o_idx       = IW'(j);
            end
        end
        o_any    = (w_best_dist < N);
        o_onehot = o_any ? (N'(1) << o_idx) : '0;
    end

endmodule

// File: rtl/gpu_dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous GPU DMEM port; 1-cycle registered read return.
// Build option: GPU_DMEM_ARB_HOSTPRIO_EN makes requester NREQ-1 win whenever it requests.
module gpu_dmem_arbiter
    import gpu_dmem_arbiter_pkg::*;
#(
    parameter int NREQ = `GPU_DMEM_ARB_NREQ,
    parameter int AW   = `GPU_DMEM_ADDR_WIDTH,
    parameter int DW   = `GPU_DMEM_DATA_WIDTH,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rd_valid,
    output logic [DW-1:0]     rd_data,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_din,
    output logic              mem_we,
    input  logic [DW-1:0]     mem_dout
);

    logic [IDW-1:0]  r_rr_ptr;
    logic [NREQ-1:0] r_rd_valid;

    logic [NREQ-1:0] w_req_live;
    logic [NREQ-1:0] w_rr_req;
    logic [NREQ-1:0] w_rr_onehot;
    logic [NREQ-1:0] w_gnt;
    logic [IDW-1:0]  w_rr_idx;
    logic            w_rr_any;
    logic            w_host_win;
    logic            w_win_any;
    logic            w_win_we;
    acc_kind_e       w_kind;

    // Masking requests in reset keeps gnt and mem_we low while rst_n is asserted.
    assign w_req_live = rst_n ? req : '0;

`ifdef GPU_DMEM_ARB_HOSTPRIO_EN
    assign w_host_win = w_req_live[NREQ-1];
    assign w_rr_req   = {1'b0, w_req_live[NREQ-2:0]};
`else
    assign w_host_win = 1'b0;
    assign w_rr_req   = w_req_live;
`endif

    gpu_rr_pick #(
        .N  (NREQ),
        .IW (IDW)
    ) u_pick (
        .i_req    (w_rr_req),
        .i_ptr    (r_rr_ptr),
        .o_onehot (w_rr_onehot),
        .o_idx    (w_rr_idx),
        .o_any    (w_rr_any)
    );

    assign w_gnt     = w_host_win ? {1'b1, {(NREQ-1){1'b0}}} : w_rr_onehot;
    assign w_win_any = w_host_win | w_rr_any;
    assign w_win_we  = |(w_gnt & req_we);
    assign w_kind    = acc_kind(w_win_any, w_win_we);

    // Memory-side mux: winner's address and data, zero when idle.
    always_comb begin
        mem_addr = '0;
        mem_din  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                mem_addr = req_addr[i*AW +: AW];
                mem_din  = req_wdata[i*DW +: DW];
            end
        end
    end

    // Pointer moves past a round-robin winner; host grants leave it where it was.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr   <= '0;
            r_rd_valid <= '0;
        end else begin
            if (w_rr_any && !w_host_win) begin
                r_rr_ptr <= (w_rr_idx == IDW'(NREQ-1)) ? '0 : w_rr_idx + IDW'(1);
            end
            r_rd_valid <= (w_kind == ACC_READ) ? w_gnt : '0;
        end
    end

    assign gnt      = w_gnt;
    assign mem_we   = (w_kind == ACC_WRITE);
    assign rd_valid = r_rd_valid;
    assign rd_data  = mem_dout;

endmodule
